// File: rtl/rx_8b10b_aligner_pkg.sv
// Shared definitions for the 8b/10b receive aligner: FSM states, comma codes
// and running-disparity encoding.
package rx_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Codes are held with the first-received bit 'a' at bit 0
   localparam logic [9:0] K28_5_NEG = 10'h17C;
   localparam logic [9:0] K28_5_POS = 10'h283;

   localparam logic RD_NEG = 1'b0;
   localparam logic RD_POS = 1'b1;

endpackage

// File: rtl/rx_8b10b_decode.sv
// Combinational 8b/10b symbol decoder with code validity and running-disparity
// checking against the current RD.
module rx_8b10b_decode
   import rx_pkg::*;
(
   input  logic [9:0] code,
   input  logic       rd_in,
   output logic [7:0] byte_val,
   output logic       is_k,
   output logic       is_comma,
   output logic       code_valid,
   output logic       rd_valid,
   output logic       rd_out
);

   function automatic logic [2:0] ones6(input logic [5:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} +
             {2'b00, v[3]} + {2'b00, v[4]} + {2'b00, v[5]};
   endfunction

   function automatic logic [2:0] ones4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   logic [5:0] s6;
   logic [3:0] s4;
   logic [3:0] s4d;
   logic [4:0] edcba;
   logic [2:0] hgf;
   logic       v6, v4, k28, a7, a7_data, kx7;
   logic       ok6, ok4, rd_mid, rd_fin;

   // Decode both sub-blocks and check them against the running disparity
   always_comb begin
      // sub-blocks reordered so the case literals read a-first
      s6 = {code[0], code[1], code[2], code[3], code[4], code[5]};
      s4 = {code[6], code[7], code[8], code[9]};

      edcba = 5'd0;
      v6    = 1'b1;
      k28   = 1'b0;
      case (s6)
         6'b100111, 6'b011000: edcba = 5'd0;
         6'b011101, 6'b100010: edcba = 5'd1;
         6'b101101, 6'b010010: edcba = 5'd2;
         6'b110001:            edcba = 5'd3;
         6'b110101, 6'b001010: edcba = 5'd4;
         6'b101001:            edcba = 5'd5;
         6'b011001:            edcba = 5'd6;
         6'b111000, 6'b000111: edcba = 5'd7;
         6'b111001, 6'b000110: edcba = 5'd8;
         6'b100101:            edcba = 5'd9;
         6'b010101:            edcba = 5'd10;
         6'b110100:            edcba = 5'd11;
         6'b001101:            edcba = 5'd12;
         6'b101100:            edcba = 5'd13;
         6'b011100:            edcba = 5'd14;
         6'b010111, 6'b101000: edcba = 5'd15;
         6'b011011, 6'b100100: edcba = 5'd16;
         6'b100011:            edcba = 5'd17;
         6'b010011:            edcba = 5'd18;
         6'b110010:            edcba = 5'd19;
         6'b001011:            edcba = 5'd20;
         6'b101010:            edcba = 5'd21;
         6'b011010:            edcba = 5'd22;
         6'b111010, 6'b000101: edcba = 5'd23;
         6'b110011, 6'b001100: edcba = 5'd24;
         6'b100110:            edcba = 5'd25;
         6'b010110:            edcba = 5'd26;
         6'b110110, 6'b001001: edcba = 5'd27;
         6'b001110:            edcba = 5'd28;
         6'b101110, 6'b010001: edcba = 5'd29;
         6'b011110, 6'b100001: edcba = 5'd30;
         6'b101011, 6'b010100: edcba = 5'd31;
         6'b001111, 6'b110000: begin
            edcba = 5'd28;
            k28   = 1'b1;
         end
         default: v6 = 1'b0;
      endcase

      // K28 in its RD+ form is the bitwise complement of the RD- form
      s4d = (s6 == 6'b110000) ? ~s4 : s4;
      hgf = 3'd0;
      v4  = 1'b1;
      a7  = 1'b0;
      case (s4d)
         4'b1011, 4'b0100: hgf = 3'd0;
         4'b1001:          hgf = 3'd1;
         4'b0101:          hgf = 3'd2;
         4'b1100, 4'b0011: hgf = 3'd3;
         4'b1101, 4'b0010: hgf = 3'd4;
         4'b1010:          hgf = 3'd5;
         4'b0110:          hgf = 3'd6;
         4'b1110, 4'b0001: hgf = 3'd7;
         4'b0111, 4'b1000: begin
            hgf = 3'd7;
            a7  = 1'b1;
         end
         default: v4 = 1'b0;
      endcase

      a7_data    = !k28 && (edcba inside {5'd11, 5'd13, 5'd14, 5'd17, 5'd18, 5'd20});
      kx7        = a7 && !k28 && (edcba inside {5'd23, 5'd27, 5'd29, 5'd30});
      is_k       = k28 || kx7;
      code_valid = v6 && v4 && (!a7 || k28 || a7_data || kx7);
      is_comma   = (code == K28_5_NEG) || (code == K28_5_POS);
      byte_val   = {hgf, edcba};

      ok6    = 1'b1;
      rd_mid = rd_in;
      if (ones6(s6) == 3'd4) begin
         ok6    = (rd_in == RD_NEG);
         rd_mid = RD_POS;
      end else if (ones6(s6) == 3'd2) begin
         ok6    = (rd_in == RD_POS);
         rd_mid = RD_NEG;
      end else if (s6 == 6'b111000) begin
         ok6 = (rd_in == RD_NEG);
      end else if (s6 == 6'b000111) begin
         ok6 = (rd_in == RD_POS);
      end else begin
         ok6 = 1'b1;
      end

      ok4    = 1'b1;
      rd_fin = rd_mid;
      if (ones4(s4) == 3'd3) begin
         ok4    = (rd_mid == RD_NEG);
         rd_fin = RD_POS;
      end else if (ones4(s4) == 3'd1) begin
         ok4    = (rd_mid == RD_POS);
         rd_fin = RD_NEG;
      end else if (s4 == 4'b1100) begin
         ok4 = (rd_mid == RD_NEG);
      end else if (s4 == 4'b0011) begin
         ok4 = (rd_mid == RD_POS);
      end else begin
         ok4 = 1'b1;
      end

      rd_valid = ok6 && ok4;
      rd_out   = rd_fin;
   end

endmodule

// File: rtl/rx_8b10b_aligner.sv
// Single-lane 8b/10b receiver: bit-serial window, K28.5 comma alignment with
// lock/unlock hysteresis, symbol decode and saturating error counting.
module rx_8b10b_aligner
   import rx_pkg::*;
#(
   parameter int LOCK_COMMAS      = 3,
   parameter int UNLOCK_ERRS      = 4,
   parameter int ERR_CNT_W        = 16,
   parameter int COMMA_ONLY_KCHAR = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 serialIn,
   input  logic                 errClear,
   output logic [7:0]           dataOut,
   output logic                 isK,
   output logic                 dataValid,
   output logic                 locked,
   output logic                 codeErr,
   output logic                 rdErr,
   output logic [ERR_CNT_W-1:0] errCount
);

   localparam logic [3:0] LOCK_N       = 4'(LOCK_COMMAS);
   localparam logic [3:0] UNLOCK_N     = 4'(UNLOCK_ERRS);
   localparam logic       KCHAR_STRICT = (COMMA_ONLY_KCHAR != 0);

   state_t     state;
   logic [9:0] window;
   logic [3:0] phase;
   logic [3:0] comma_cnt;
   logic [3:0] consec_err;
   logic       rd;

   logic [7:0] dec_byte;
   logic       dec_k, dec_comma, dec_code_valid, dec_rd_valid, dec_rd_out;
   logic       boundary, code_ok, sym_good, err_now;

   rx_8b10b_decode u_decode (
      .code       (window),
      .rd_in      (rd),
      .byte_val   (dec_byte),
      .is_k       (dec_k),
      .is_comma   (dec_comma),
      .code_valid (dec_code_valid),
      .rd_valid   (dec_rd_valid),
      .rd_out     (dec_rd_out)
   );

   // Symbol qualification for the aligned window
   always_comb begin
      boundary = (phase == 4'd0);
      code_ok  = dec_code_valid && !(KCHAR_STRICT && dec_k && !dec_comma);
      sym_good = code_ok && dec_rd_valid;
      err_now  = (state == LOCKED) && boundary && !sym_good;
   end

   // Serial window: newest bit enters at the top, 'a' ends at bit 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         window <= 10'd0;
      end else begin
         window <= {serialIn, window[9:1]};
      end
   end

   // Alignment FSM, phase tracking, disparity and registered symbol outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= HUNT;
         phase      <= 4'd0;
         comma_cnt  <= 4'd0;
         consec_err <= 4'd0;
         rd         <= RD_NEG;
         dataOut    <= 8'd0;
         isK        <= 1'b0;
         dataValid  <= 1'b0;
         locked     <= 1'b0;
         codeErr    <= 1'b0;
         rdErr      <= 1'b0;
      end else begin
         dataValid <= 1'b0;
         codeErr   <= 1'b0;
         rdErr     <= 1'b0;
         phase     <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;
         case (state)
            HUNT: begin
               phase <= 4'd0;
               if (dec_comma) begin
                  // the match cycle itself is phase 0
                  phase     <= 4'd1;
                  comma_cnt <= 4'd1;
                  rd        <= (window == K28_5_NEG) ? RD_POS : RD_NEG;
                  if (LOCK_N == 4'd1) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                  end else begin
                     state <= SYNC;
                  end
               end
            end
            SYNC: begin
               if (boundary) begin
                  if (!sym_good) begin
                     state     <= HUNT;
                     comma_cnt <= 4'd0;
                     phase     <= 4'd0;
                  end else begin
                     rd <= dec_rd_out;
                     if (dec_comma) begin
                        comma_cnt <= comma_cnt + 4'd1;
                        if (comma_cnt + 4'd1 == LOCK_N) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                     end
                  end
               end
            end
            LOCKED: begin
               if (boundary) begin
                  if (sym_good) begin
                     dataOut    <= dec_byte;
                     isK        <= dec_k;
                     dataValid  <= 1'b1;
                     consec_err <= 4'd0;
                     rd         <= dec_rd_out;
                  end else begin
                     if (!code_ok) begin
                        codeErr <= 1'b1;
                     end else begin
                        rdErr <= 1'b1;
                        rd    <= dec_rd_out;
                     end
                     if (consec_err + 4'd1 == UNLOCK_N) begin
                        state      <= HUNT;
                        locked     <= 1'b0;
                        consec_err <= 4'd0;
                        comma_cnt  <= 4'd0;
                        phase      <= 4'd0;
                     end else begin
                        consec_err <= consec_err + 4'd1;
                     end
                  end
               end
            end
            default: begin
               state  <= HUNT;
               locked <= 1'b0;
            end
         endcase
      end
   end

   // Saturating error counter; a clear coinciding with an error leaves 1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         errCount <= '0;
      end else if (errClear) begin
         errCount <= {{(ERR_CNT_W-1){1'b0}}, err_now};
      end else if (err_now && (errCount != {ERR_CNT_W{1'b1}})) begin
         errCount <= errCount + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         errCount <= errCount;
      end
   end

endmodule

// File: doc/rx_8b10b_aligner.md
Name: rx_8b10b_aligner

Overview:
Parametrised successor to the team's single-lane SERDES receiver. It deserialises one serial 8b/10b lane and locates the symbol boundary at any bit offset using K28.5 commas of either disparity. Lock is gained and lost under a programmable hysteresis FSM, and running disparity is tracked. It emits decoded bytes with K flags, error pulses and a saturating error counter to the downstream VGA/data sink.

Parameters:
LOCK_COMMAS, 3, aligned commas (including the first) required to enter LOCKED; range 1..15
UNLOCK_ERRS, 4, consecutive bad symbols in LOCKED that force return to HUNT; range 1..15
ERR_CNT_W, 16, width of the saturating error counter
COMMA_ONLY_KCHAR, 0, when 1, K-codes other than K28.5 are reported as code errors

Ports:
clk  in  1  single system clock, one serial bit per cycle
reset  in  1  asynchronous, active-high reset
serialIn  in  1  serial bit, 'a' first per symbol
errClear  in  1  synchronous pulse, zeroes errCount
dataOut  out  8  decoded byte HGFEDCBA, registered
isK  out  1  dataOut is a K-code, qualified by dataValid
dataValid  out  1  one-cycle pulse per decoded symbol in LOCKED
locked  out  1  high while the FSM is in LOCKED
codeErr  out  1  one-cycle pulse: invalid 10b code at a LOCKED symbol boundary
rdErr  out  1  one-cycle pulse: valid code with wrong disparity at a LOCKED boundary
errCount  out  ERR_CNT_W  saturating count of codeErr|rdErr events

Behaviour:
- Reset (async, active-high): all outputs 0; FSM=HUNT; RD=negative (-1); window, phase counter and comma/consecutive-error counters cleared.
- Window: 10-bit shift register; each clk the new bit enters bit 9 and shifts right, so the first-received bit 'a' ends at bit 0.
- Comma match: 10'h17C (RD-) or 10'h283 (RD+).
- HUNT: window tested every cycle. On a match, phase counter=0 (boundary now), commaCnt=1, RD set to the value after that comma (0x17C -> +, 0x283 -> -), go to SYNC. If LOCK_COMMAS=1, go directly to LOCKED.
- Phase counter: counts 0..9 and wraps; boundary tick when it wraps to 0, i.e. every 10 cycles after alignment.
- SYNC, at each boundary:
  - comma: commaCnt++; when it reaches LOCK_COMMAS, go to LOCKED.
  - valid non-comma: commaCnt held; RD updated.
  - invalid code or disparity error: go to HUNT, commaCnt=0.
  - No outputs are produced in SYNC.
- LOCKED, at each boundary: decode via sub-module.
  - Good symbol: dataOut/isK registered, dataValid=1 for one cycle, consecErr=0, RD updated.
  - Bad symbol: codeErr or rdErr pulses (codeErr has priority if both apply), dataValid=0, consecErr++, dataOut holds its previous value. On rdErr, RD is still updated from the received code.
  - When consecErr reaches UNLOCK_ERRS: go to HUNT, locked drops the same cycle the FSM changes, counters clear.
- Comma seen off-boundary while LOCKED: ignored, no realignment.
- Latency: the last bit of a symbol is sampled on edge N; dataOut/dataValid/errors are visible after edge N+1.
- errCount: +1 on each codeErr|rdErr pulse; saturates at all-ones. errClear takes priority; errClear together with an error gives 1.
- Reset mid-symbol: state and window discarded immediately; realignment restarts from HUNT.
- Disparity rules: a neutral code keeps RD; a +2 code requires RD- and flips it to +; a -2 code requires RD+ and flips it to -. D.07 alternates are accepted per the standard.

Decomposition:
- Shared package rx_pkg: state encoding (HUNT, SYNC, LOCKED), comma constants K28_5_NEG=10'h17C and K28_5_POS=10'h283, RD encoding.
- One sub-module rx_8b10b_decode: combinational; inputs code[9:0] and rdIn; outputs byte, isK, isComma, codeValid, rdValid, rdOut.
- Top level: shift register, phase counter, FSM, counters, output registers.

Test Plan:
- Idle 0s, then K28.5(-), K28.5(+), K28.5(-) at bit offset 7, LOCK_COMMAS=3 -> locked rises 1 cycle after the third comma completes; no dataValid before that.
- Locked, send D21.5 (0x55... as 1010101010) then D0.0 RD+ -> dataValid pulses with dataOut=0xB5 then 0x00, isK=0, no errors.
- Locked, inject 10'h000 once, then good data -> single codeErr pulse, errCount=1, locked stays 1, consecErr resets.
- Locked, 4 consecutive invalid codes, UNLOCK_ERRS=4 -> four codeErr pulses, errCount=4, locked falls after the 4th; a new comma at a different offset relocks.
- Locked, send D3.0 with wrong disparity form -> rdErr=1, codeErr=0; errClear asserted the same cycle -> errCount=1.
- Assert reset mid-symbol while locked -> all outputs 0 asynchronously; after release, HUNT is entered and a full relock is required.
